// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg
//   Shared definitions for the pipeline stage register: state encodings,
//   reset/enable polarities, the live-entry counter type and a helper that
//   derives the live count from the state.
//   No ports (package).
package pipe_stage_skid_pkg;

    // Reset is active-low, load enables are active-high.
    localparam logic RESET_ENABLE = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;

    // Live-entry counter bus.
    typedef logic [1:0] pipe_cnt_t;

    // State is exactly the pair {main_v, skid_v}.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_ONE   = 2'b10,
        PIPE_TWO   = 2'b11
    } pipe_state_e;

    function automatic pipe_cnt_t live_count(input pipe_state_e s);
        logic [1:0] bits;
        bits = s;
        return pipe_cnt_t'({1'b0, bits[1]}) + pipe_cnt_t'({1'b0, bits[0]});
    endfunction

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// pipe_entry
//   DATA_W-wide hold register with a load enable and an asynchronous reset
//   value. Holds its contents whenever load_i is inactive.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous, active-low reset (loads RESET_VAL)
//   load_i  - load enable
//   data_i  - value loaded when load_i is active
//   data_o  - registered contents
module pipe_entry
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W    = 160,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            data_q <= RESET_VAL;
        end else if (load_i == WRITE_ENABLE) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Pipeline stage register with a valid/ready handshake, an optional skid
//   entry and a synchronous flush. With SKID=1 the stage holds up to two
//   payloads and in_ready_o comes straight from a flop; with SKID=0 it holds
//   one payload and ready depends combinationally on out_ready_i.
// Ports:
//   clock        - rising-edge clock
//   reset        - asynchronous, active-low reset
//   flush_i      - synchronous kill of all held entries (highest priority)
//   in_valid_i   - upstream offers in_data_i
//   in_ready_o   - stage can accept this cycle
//   in_data_i    - upstream payload
//   out_valid_o  - output entry holds a live payload
//   out_ready_i  - downstream accepts out_data_o
//   out_data_o   - registered payload
//   count_o      - number of live entries (0..2)
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W     = 160,
    parameter int                SKID       = 1,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    pipe_state_e       state_q, state_d;
    logic              main_v;
    logic              in_xfer, out_xfer;
    logic              main_ld, main_from_skid;
    logic              skid_ld;
    logic [DATA_W-1:0] main_val, skid_val, skid_data;

    assign main_v   = state_q[1];
    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = main_v & out_ready_i;

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            state_q <= PIPE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_val       = in_data_i;
        if (flush_i) begin
            // Kill both entries; the output payload is left as it was so a
            // same-cycle downstream transfer still sees stable data.
            state_d  = PIPE_EMPTY;
            skid_ld  = 1'b1;
            skid_val = RESET_DATA;
        end else begin
            unique case (state_q)
                PIPE_EMPTY: begin
                    if (in_xfer) begin
                        main_ld = 1'b1;
                        state_d = PIPE_ONE;
                    end
                end
                PIPE_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ld = 1'b1;
                    end else if (out_xfer) begin
                        state_d = PIPE_EMPTY;
                    end else if (in_xfer && (SKID != 0)) begin
                        skid_ld = 1'b1;
                        state_d = PIPE_TWO;
                    end
                end
                PIPE_TWO: begin
                    if (out_xfer) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = PIPE_ONE;
                    end
                end
                default: state_d = PIPE_EMPTY;
            endcase
        end
    end

    assign main_val = main_from_skid ? skid_data : in_data_i;

    pipe_entry #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_DATA)
    ) u_main (
        .clock  (clock),
        .reset  (reset),
        .load_i (main_ld),
        .data_i (main_val),
        .data_o (out_data_o)
    );

    if (SKID != 0) begin : g_skid
        logic in_ready_q;

        pipe_entry #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_DATA)
        ) u_skid (
            .clock  (clock),
            .reset  (reset),
            .load_i (skid_ld),
            .data_i (skid_val),
            .data_o (skid_data)
        );

        // Ready tracks the next skid-valid, so it equals !skid_v from the
        // first edge after reset onward and is low during/just after reset.
        always_ff @(posedge clock or negedge reset) begin
            if (reset == RESET_ENABLE) begin
                in_ready_q <= 1'b0;
            end else begin
                in_ready_q <= ~state_d[0];
            end
        end

        assign in_ready_o = in_ready_q;
    end else begin : g_no_skid
        logic unused_skid;
        assign unused_skid = ^{skid_ld, skid_val};
        assign skid_data   = RESET_DATA;
        // Single entry: accept when empty or when the held payload leaves now.
        assign in_ready_o  = ~main_v | out_ready_i;
    end

    assign out_valid_o = main_v;
    assign count_o     = live_count(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance share the
//   stimulus; a queue-based reference model tracks whichever is selected.
module tb_pipe_stage_skid;

    localparam int           W     = 16;
    localparam logic [W-1:0] RST_D = 16'h5A5A;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush_i;
    logic         in_valid_i;
    logic         out_ready_i;
    logic [W-1:0] in_data_i;

    logic         rdy1, vld1, rdy0, vld0;
    logic [W-1:0] dat1, dat0;
    logic [1:0]   cnt1, cnt0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           sel_skid;
    logic [W-1:0] q[$];
    logic [W-1:0] m_out;
    bit           post_rst;

    always #5 clock = ~clock;

    pipe_stage_skid #(.DATA_W(W), .SKID(1), .RESET_DATA(RST_D)) dut_skid (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (rdy1),
        .in_data_i   (in_data_i),
        .out_valid_o (vld1),
        .out_ready_i (out_ready_i),
        .out_data_o  (dat1),
        .count_o     (cnt1)
    );

    pipe_stage_skid #(.DATA_W(W), .SKID(0), .RESET_DATA(RST_D)) dut_noskid (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (rdy0),
        .in_data_i   (in_data_i),
        .out_valid_o (vld0),
        .out_ready_i (out_ready_i),
        .out_data_o  (dat0),
        .count_o     (cnt0)
    );

    function automatic bit m_ready();
        if (sel_skid) return !post_rst && (q.size() < 2);
        return (q.size() == 0) || out_ready_i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic         r, v;
        logic [W-1:0] d;
        logic [1:0]   c;
        if (sel_skid) begin
            r = rdy1; v = vld1; d = dat1; c = cnt1;
        end else begin
            r = rdy0; v = vld0; d = dat0; c = cnt0;
        end
        chk({tag, ".ready"}, 32'(r), 32'(m_ready()));
        chk({tag, ".valid"}, 32'(v), 32'(q.size() != 0));
        chk({tag, ".data"},  32'(d), 32'(m_out));
        chk({tag, ".count"}, 32'(c), 32'(q.size()));
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic step(input string tag);
        bit inx, outx;
        @(negedge clock);
        chk_all(tag);
        inx  = in_valid_i && m_ready();
        outx = out_ready_i && (q.size() != 0);
        @(posedge clock);
        if (reset) begin
            if (flush_i) begin
                q.delete();
            end else begin
                if (outx) void'(q.pop_front());
                if (inx) q.push_back(in_data_i);
            end
            if (q.size() != 0) m_out = q[0];
            post_rst = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_out    = RST_D;
        post_rst = 1'b1;
    endtask

    task automatic idle_inputs();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        in_data_i   = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        step("rst_hold");
        step("rst_hold");
        reset = 1'b1;   // released between edges
    endtask

    task automatic random_run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            in_data_i   = W'($urandom);
            flush_i     = ($urandom_range(0, 15) == 0);
            step(tag);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        sel_skid = 1'b1;
        #2;

        // ---- SKID=1: reset release
        apply_reset();
        step("rel_first");
        step("rel_second");
        chk("rel_ready_high", 32'(rdy1), 32'd1);

        // ---- Streaming 1..16 with downstream always ready
        out_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = W'(i);
            step("stream");
        end
        in_valid_i = 1'b0;
        step("stream_tail");
        step("stream_tail");

        // ---- Backpressure: 0xA, 0xB held while downstream stalls
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 16'h000A;
        step("bp_a");
        in_data_i   = 16'h000B;
        step("bp_b");
        in_valid_i  = 1'b0;
        for (int i = 0; i < 5; i++) step("bp_stall");
        chk("bp_count", 32'(cnt1), 32'd2);
        chk("bp_hold", 32'(dat1), 32'h000A);
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step("bp_drain");

        // ---- Flush in TWO with 0xC offered
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 16'h0011;
        step("fl_fill");
        in_data_i   = 16'h0022;
        step("fl_fill");
        in_data_i   = 16'h000C;
        flush_i     = 1'b1;
        step("fl_edge");
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        chk("fl_count", 32'(cnt1), 32'd0);
        chk("fl_valid", 32'(vld1), 32'd0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step("fl_after");

        // ---- Asynchronous reset while in TWO
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 16'h0033;
        step("ar_fill");
        in_data_i   = 16'h0044;
        step("ar_fill");
        in_valid_i  = 1'b0;
        chk("ar_pre_count", 32'(cnt1), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_ready", 32'(rdy1), 32'd0);
        chk("ar_valid", 32'(vld1), 32'd0);
        chk("ar_data",  32'(dat1), 32'(RST_D));
        chk("ar_count", 32'(cnt1), 32'd0);
        model_reset();
        step("ar_hold");
        reset = 1'b1;
        step("ar_rel");
        step("ar_rel2");

        // ---- SKID=1 randomized traffic
        random_run(400, "rnd_skid");
        step("rnd_skid_end");

        // ---- SKID=0
        sel_skid = 1'b0;
        apply_reset();
        step("ns_rel");
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 16'h0101;
        step("ns_fill");
        in_data_i   = 16'h0202;
        #1;
        chk("ns_full_stall_ready", 32'(rdy0), 32'd0);
        step("ns_stall");
        out_ready_i = 1'b1;
        #1;
        chk("ns_full_flow_ready", 32'(rdy0), 32'd1);
        step("ns_replace");
        chk("ns_replaced_data", 32'(dat0), 32'h0202);
        chk("ns_replaced_count", 32'(cnt0), 32'd1);
        in_valid_i = 1'b0;
        step("ns_drain");
        random_run(300, "rnd_noskid");
        step("rnd_noskid_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, an optional skid entry, and a synchronous flush. It replaces the fixed-field, write-enable-only stage registers between decode/execute/memory/writeback. The payload is one flat vector, so every stage boundary uses the same block. With the skid entry enabled, upstream ready comes from a flop and never depends combinationally on downstream ready.

## Interface
Parameters:
- DATA_W, default 160: payload width in bits. Must be ≥ 1.
- SKID, default 1: 1 gives a two-entry stage with a registered `in_ready_o`; 0 gives a single entry with a combinational ready path.
- RESET_DATA, default 0: value `out_data_o` and the skid entry take in reset and after flush. Width is DATA_W.

Ports:
- clock: input, 1 bit. Rising-edge clock.
- reset: input, 1 bit. Asynchronous, active-low reset.
- flush_i: input, 1 bit. Synchronous kill of all held entries.
- in_valid_i: input, 1 bit. Upstream offers `in_data_i`.
- in_ready_o: output, 1 bit. Stage can accept this cycle.
- in_data_i: input, DATA_W bits. Upstream payload.
- out_valid_o: output, 1 bit. The output entry holds a live payload.
- out_ready_i: input, 1 bit. Downstream accepts `out_data_o`.
- out_data_o: output, DATA_W bits. Registered payload.
- count_o: output, 2 bits. Number of live entries (0..2).

## Operation
- Input transfer: `in_valid_i & in_ready_o` at a rising edge. Output transfer: `out_valid_o & out_ready_i`.
- States, encoded from two flops (`main_v`, `skid_v`):
  - EMPTY = 00
  - ONE = 10
  - TWO = 11. TWO is reachable only when SKID=1.
- EMPTY:
  - On input transfer, load `in_data_i` into main and go to ONE.
- ONE:
  - Input and output transfer together: main takes `in_data_i`; state stays ONE.
  - Output transfer only: go to EMPTY; main data holds its value.
  - Input transfer only: with SKID=1, `in_data_i` goes to skid and state goes to TWO. With SKID=0 this case cannot occur because ready is low.
- TWO:
  - `in_ready_o` = 0.
  - On output transfer, main takes skid data, skid goes invalid, state goes to ONE.
- in_ready_o:
  - SKID=1: registered, equal to `!skid_v`. It is additionally forced to 0 while reset is asserted and for the first edge after reset releases.
  - SKID=0: `!main_v | out_ready_i`, combinational.
- Flush:
  - `flush_i` = 1 at an edge sets state to EMPTY and loads skid data with RESET_DATA.
  - `out_data_o` holds its value.
  - Any input transfer in the same cycle is dropped.
  - An output transfer in the same cycle still counts downstream.
  - Flush has priority over all other events.
- Data flops load only on the transfers above. Otherwise they hold their value, so a stall is a hold.
- count_o = `main_v + skid_v`.

## Timing
- Latency: input accepted at edge N makes `out_valid_o` = 1 after edge N when the stage was EMPTY.
- Throughput: one transfer per cycle under continuous flow.
- A stall of any length with `out_ready_i` = 0 leaves the payload unchanged.
- Reset (`reset` = 0, asynchronous) forces:
  - `out_valid_o` = 0
  - `out_data_o` = RESET_DATA
  - `count_o` = 0
  - `in_ready_o` = 0, which becomes 1 one edge after release.
  - state EMPTY
- Reset mid-operation discards both entries immediately, with no partial transfer.
- Simultaneous input transfer and output transfer in TWO cannot occur, because ready is low.
- `in_valid_i` may drop without a transfer. The stage never requires upstream to hold valid.

## Structure
- Add to `defines.v`:
  - `PIPE_CNT_BUS` = 1:0.
  - State encodings `PIPE_EMPTY`, `PIPE_ONE`, `PIPE_TWO`.
  - Reuse `RESET_ENABLE` and `WRITE_ENABLE` for reset and enable polarity.
- One sub-module, `pipe_entry`: a DATA_W-wide hold register with a load enable, a load value and an asynchronous reset value. It is instantiated for main, and for skid under `generate if (SKID)`.
- The control FSM lives in the top module, in a single always block.

## Test plan
- Reset release, SKID=1:
  - Required: `in_ready_o` = 0 in the first cycle, then 1.
  - Required: `out_valid_o` = 0 and `out_data_o` = RESET_DATA throughout.
- Streaming 0x1..0x10 with `out_ready_i` held at 1:
  - Required: the outputs appear in order, one per cycle, one cycle late.
  - Required: `count_o` stays 1.
- Backpressure: send 0xA then 0xB while `out_ready_i` = 0.
  - Required: `count_o` = 2 and `in_ready_o` = 0, and `out_data_o` holds 0xA for 5 cycles.
  - Then raise `out_ready_i`. Required: 0xA then 0xB are delivered, and `in_ready_o` returns to 1.
- Flush in TWO while `in_valid_i` = 1 with 0xC:
  - Required: next cycle `count_o` = 0 and `out_valid_o` = 0.
  - Required: 0xC is never delivered.
- SKID=0, stage full, `out_ready_i` = 1, `in_valid_i` = 1:
  - Required: `in_ready_o` = 1 in the same cycle and the replacement transfer happens.
  - With `out_ready_i` = 0: required `in_ready_o` = 0.
- Asynchronous reset asserted mid-edge while in TWO:
  - Required: outputs go to their reset values immediately, with no edge needed.
